pll_lock_sequencer: RTL and testbench

- Sits directly downstream of the PLL wrapper and is clocked by its buffered output clock.
- Synchronizes the PLL `locked` flag and waits for lock to stay stable for a settle period.
- Only then releases a registered active-low reset to the DDS core.
- On lock loss, immediately re-asserts core reset, records the event in sticky status, enforces a hold-off period, then re-arms.

---
 rtl/pll_seq_pkg.sv | 18 +
 rtl/sync_bit.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and constants for the PLL lock sequencer
package pll_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_SETTLE    = 2'd1,
        ST_RUN       = 2'd2,
        ST_HOLDOFF   = 2'd3
    } state_t;

    // Consecutive low lock_s cycles before a loss is declared when filtering is enabled
    localparam int GLITCH_LEN = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - parameterized flop-chain synchronizer with async active-low reset to 0
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL lock qualification and DDS core reset sequencing
// Optional macro: LOCK_GLITCH_FILTER_EN (debounce lock loss while in RUN)
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             clear_flags,
    output logic             core_reset_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [2:0]       state_dbg
);

    localparam int CW = $clog2(max_int(SETTLE_CYCLES, HOLDOFF_CYCLES) + 1);
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          lock_s;
    logic          loss_event;
    logic          run_ok;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked),
        .q       (lock_s)
    );

`ifdef LOCK_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_LEN + 1);
    localparam logic [GW-1:0] GLITCH_FULL = GW'(GLITCH_LEN);

    logic [GW-1:0] glitch_cnt;

    // Counts consecutive low lock_s cycles in RUN; any high cycle before full length restarts it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            glitch_cnt <= '0;
        end else if (state != ST_RUN || glitch_cnt == GLITCH_FULL) begin
            glitch_cnt <= '0;
        end else if (!lock_s) begin
            glitch_cnt <= glitch_cnt + GW'(1);
        end else begin
            glitch_cnt <= '0;
        end
    end

    assign loss_event = (state == ST_RUN) && (glitch_cnt == GLITCH_FULL);
`else
    assign loss_event = (state == ST_RUN) && !lock_s;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (loss_event) begin
                    state_next = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                // Lock state is deliberately ignored until the hold-off expires
                if (cnt == HOLDOFF_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = ST_WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Release lags RUN entry by one cycle; a loss pulls reset on the same edge it is seen
    assign run_ok = (state == ST_RUN) && !loss_event;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_reset_n <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
            loss_count   <= '0;
        end else begin
            core_reset_n <= run_ok;
            ready        <= run_ok;
            if (loss_event) begin
                lock_lost <= 1'b1;
                if (clear_flags) begin
                    loss_count <= CNT_W'(1);
                end else if (loss_count != COUNT_MAX) begin
                    loss_count <= loss_count + CNT_W'(1);
                end
            end else if (clear_flags) begin
                lock_lost  <= 1'b0;
                loss_count <= '0;
            end
        end
    end

    assign state_dbg = {1'b0, state};

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int SETTLE_CYCLES  = 16;
    localparam int HOLDOFF_CYCLES = 8;
    localparam int CNT_W          = 8;
`ifdef LOCK_GLITCH_FILTER_EN
    localparam int PULSE     = 4;
    localparam int LOSS_EDGE = 6;
`else
    localparam int PULSE     = 1;
    localparam int LOSS_EDGE = 2;
`endif

    logic             clock;
    logic             reset_n;
    logic             locked;
    logic             clear_flags;
    logic             core_reset_n;
    logic             ready;
    logic             lock_lost;
    logic [CNT_W-1:0] loss_count;
    logic [2:0]       state_dbg;

    int passed;
    int total;

    pll_lock_sequencer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .locked       (locked),
        .clear_flags  (clear_flags),
        .core_reset_n (core_reset_n),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .loss_count   (loss_count),
        .state_dbg    (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input logic val, input int budget, output int n);
        n = 0;
        while (ready !== val && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_low();
        for (int p = 0; p < PULSE; p++) begin
            locked = 1'b0;
            tick();
        end
        locked = 1'b1;
    endtask

    initial begin
        int n;
        int timeouts;
        passed      = 0;
        total       = 0;
        timeouts    = 0;
        reset_n     = 1'b0;
        locked      = 1'b0;
        clear_flags = 1'b0;

        // Power-up
        repeat (5) tick();
        check("rst_core", core_reset_n, 0);
        check("rst_ready", ready, 0);
        check("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        repeat (30) tick();
        check("idle_core", core_reset_n, 0);
        check("idle_lost", lock_lost, 0);
        check("idle_count", loss_count, 0);
        check("idle_state", state_dbg, 0);

        // Lock lost during SETTLE
        locked = 1'b1;
        repeat (10) tick();
        check("settle_state", state_dbg, 1);
        locked = 1'b0;
        repeat (2) tick();
        check("settle_e11", state_dbg, 1);
        tick();
        check("abort_state", state_dbg, 0);
        check("abort_lost", lock_lost, 0);
        check("abort_count", loss_count, 0);
        check("abort_core", core_reset_n, 0);

        // Clean lock: release after edge 19
        locked = 1'b1;
        for (int e = 0; e <= 19; e++) begin
            tick();
            if (e == 17) check("lock_e17_state", state_dbg, 1);
            if (e == 18) check("lock_e18_state", state_dbg, 2);
            if (e >= 17) check($sformatf("lock_core_e%0d", e), core_reset_n, (e >= 19) ? 1 : 0);
        end
        check("lock_ready", ready, 1);

        // Loss in RUN
        for (int e = 0; e <= LOSS_EDGE; e++) begin
            locked = (e < PULSE) ? 1'b0 : 1'b1;
            tick();
            if (e == LOSS_EDGE - 1) check("loss_core_before", core_reset_n, 1);
        end
        check("loss_core", core_reset_n, 0);
        check("loss_ready", ready, 0);
        check("loss_lost", lock_lost, 1);
        check("loss_count", loss_count, 1);
        check("loss_state", state_dbg, 3);
        for (int h = 1; h < HOLDOFF_CYCLES; h++) begin
            tick();
            check($sformatf("holdoff_%0d", h), state_dbg, 3);
        end
        tick();
        check("holdoff_exit", state_dbg, 0);
        wait_ready(1'b1, 40, n);
        check("relock_latency", n, 18);

`ifdef LOCK_GLITCH_FILTER_EN
        // Short glitch in RUN is ignored
        for (int p = 0; p < 3; p++) begin
            locked = 1'b0;
            tick();
        end
        locked = 1'b1;
        repeat (10) tick();
        check("glitch_core", core_reset_n, 1);
        check("glitch_state", state_dbg, 2);
        check("glitch_count", loss_count, 1);
`endif

        // Saturation
        for (int i = 0; i < 300; i++) begin
            pulse_low();
            wait_ready(1'b0, 20, n);
            if (ready !== 1'b0) timeouts++;
            wait_ready(1'b1, 60, n);
            if (ready !== 1'b1) timeouts++;
        end
        check("sat_timeouts", timeouts, 0);
        check("sat_count", loss_count, 255);
        check("sat_lost", lock_lost, 1);

        // Clear
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_lost", lock_lost, 0);
        check("clr_count", loss_count, 0);
        check("clr_state", state_dbg, 2);
        check("clr_core", core_reset_n, 1);

        // Clear coincident with a loss: loss wins
        pulse_low();
        wait_ready(1'b0, 20, n);
        wait_ready(1'b1, 60, n);
        check("pre_coinc_count", loss_count, 1);
        for (int e = 0; e <= LOSS_EDGE; e++) begin
            locked      = (e < PULSE) ? 1'b0 : 1'b1;
            clear_flags = (e == LOSS_EDGE);
            tick();
        end
        clear_flags = 1'b0;
        check("coinc_lost", lock_lost, 1);
        check("coinc_count", loss_count, 1);
        check("coinc_state", state_dbg, 3);

        // Asynchronous reset from RUN
        wait_ready(1'b1, 60, n);
        check("pre_arst_core", core_reset_n, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_core", core_reset_n, 0);
        check("arst_lost", lock_lost, 0);
        check("arst_count", loss_count, 0);
        check("arst_state", state_dbg, 0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
